// File: rtl/aead_bus_ctrl_mc.sv
// aead_bus_ctrl_mc: multi-channel register bank and command dispatcher in front of AEAD cipher cores
module aead_bus_ctrl_mc #(
  parameter int N_CH = 4,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 8,
  parameter int CMD_DEPTH = 4,
  parameter logic [31:0] ID_VALUE = 32'h41454144
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic [N_CH-1:0]        core_init,
  output logic [N_CH-1:0]        core_next,
  output logic [N_CH-1:0]        core_done,
  output logic [N_CH*DATA_W-1:0] core_key,
  output logic [N_CH*DATA_W-1:0] core_nonce,
  output logic [N_CH*DATA_W-1:0] core_data,
  input  logic [N_CH-1:0]        core_ready,
  input  logic [N_CH-1:0]        core_result_valid,
  input  logic [N_CH*DATA_W-1:0] core_result,
  output logic                   irq
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  logic [3:0] reg_a;
  logic [ADDR_W-5:0] ch;
  logic [DATA_W-1:0] rd_val [N_CH];
  logic [DATA_W-1:0] rsel;
  logic [N_CH-1:0] irq_v;
  assign reg_a = address[3:0];
  assign ch = address[ADDR_W-1:4];
  assign irq = |irq_v;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t st;
    logic [2:0] fifo [CMD_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] key, nonce, data, result;
    logic rv, ov, il, ie;
    logic [15:0] err;
    logic [2:0] pulse;
    logic [CW+7:0] status;
    logic hit, cmd_wr, legal, full, pop, push, ovf, ill, busy, dwr, err_inc, clr;
    assign hit = cs && int'(ch) == c;
    assign cmd_wr = hit && we && reg_a == 4'd1;
    assign legal = $onehot(write_data[2:0]);
    assign full = cnt == CW'(CMD_DEPTH);
    assign pop = st == IDLE && cnt != '0 && core_ready[c];
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign push = cmd_wr && legal && (!full || pop);
    assign ovf = cmd_wr && legal && full && !pop;
    assign ill = cmd_wr && write_data[2:0] != 3'b000 && !legal;
    assign busy = st != IDLE || cnt != '0;
    assign dwr = hit && we && reg_a inside {4'd3, 4'd4, 4'd5};
    assign err_inc = ovf || ill || (dwr && busy);
    assign clr = cmd_wr && write_data[7];
    assign status = {cnt, 3'b000, ie, il, ov, rv, st == IDLE && cnt == '0 && core_ready[c]};
    assign rd_val[c] = reg_a == 4'd0 ? DATA_W'(ID_VALUE) :
                       reg_a == 4'd1 ? DATA_W'({ie, 4'b0000}) :
                       reg_a == 4'd2 ? DATA_W'(status) :
                       reg_a == 4'd3 ? key :
                       reg_a == 4'd4 ? nonce :
                       reg_a == 4'd5 ? data :
                       reg_a == 4'd6 ? result :
                       reg_a == 4'd7 ? DATA_W'(err) : '0;
    assign core_init[c] = pulse[0];
    assign core_next[c] = pulse[1];
    assign core_done[c] = pulse[2];
    assign core_key[c*DATA_W +: DATA_W] = key;
    assign core_nonce[c*DATA_W +: DATA_W] = nonce;
    assign core_data[c*DATA_W +: DATA_W] = data;
    assign irq_v[c] = rv & ie;
    always_ff @(posedge clk) begin
      if (rst) begin
        st <= IDLE;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        pulse <= '0;
        key <= '0;
        nonce <= '0;
        data <= '0;
        result <= '0;
        rv <= 1'b0;
        ov <= 1'b0;
        il <= 1'b0;
        ie <= 1'b0;
        err <= '0;
      end else begin
        pulse <= pop ? fifo[rp] : 3'b000;
        st <= pop ? ISSUE : st == ISSUE ? WAIT : (st == WAIT && core_ready[c]) ? IDLE : st;
        rp <= pop ? rp + 1'b1 : rp;
        if (push) begin
          fifo[wp] <= write_data[2:0];
          wp <= wp + 1'b1;
        end
        cnt <= cnt + CW'(push) - CW'(pop);
        if (dwr && !busy && reg_a == 4'd3) key <= write_data;
        if (dwr && !busy && reg_a == 4'd4) nonce <= write_data;
        if (dwr && !busy && reg_a == 4'd5) data <= write_data;
        if (cmd_wr) ie <= write_data[4];
        // a capture on the same edge as a RESULT read keeps the flag set
        if (core_result_valid[c]) result <= core_result[c*DATA_W +: DATA_W];
        rv <= core_result_valid[c] || (rv && !(hit && !we && reg_a == 4'd6));
        ov <= !clr && (ov || ovf);
        il <= !clr && (il || ill);
        err <= clr ? '0 : (err_inc && err != 16'hFFFF) ? err + 16'd1 : err;
      end
    end
  end
  always_comb begin
    rsel = '0;
    for (int i = 0; i < N_CH; i++) rsel = int'(ch) == i ? rd_val[i] : rsel;
  end
  always_ff @(posedge clk) read_data <= rst ? '0 : (cs && !we) ? rsel : read_data;
endmodule

// File: tb/tb_aead_bus_ctrl_mc.sv
// tb_aead_bus_ctrl_mc: directed stimulus checked against a queue-based channel model every cycle
module tb_aead_bus_ctrl_mc;
  localparam int N = 4, W = 512, AW = 8, D = 4;
  logic clk = 1'b0, rst, cs, we, irq;
  logic [AW-1:0] address;
  logic [W-1:0] write_data, read_data;
  logic [N-1:0] core_init, core_next, core_done, core_ready, core_result_valid;
  logic [N*W-1:0] core_key, core_nonce, core_data, core_result;
  int errors = 0, checks = 0;

  aead_bus_ctrl_mc #(.N_CH(N), .DATA_W(W), .ADDR_W(AW), .CMD_DEPTH(D), .ID_VALUE(32'h41454144)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .core_init(core_init), .core_next(core_next), .core_done(core_done),
    .core_key(core_key), .core_nonce(core_nonce), .core_data(core_data), .core_ready(core_ready),
    .core_result_valid(core_result_valid), .core_result(core_result), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // channel model: commands live in a queue, phase 0 idle / 1 pulsing / 2 waiting for the core
  logic [2:0] mq [N][$];
  int mph [N];
  logic [2:0] mcmd [N];
  logic [W-1:0] mkey [N], mnon [N], mdat [N], mres [N], mread;
  bit mrv [N], mov [N], mil [N], mie [N];
  int merr [N];
  bit mlive = 0;

  function automatic logic [W-1:0] mview(int c, int r);
    if (c >= N) return '0;
    case (r)
      0: return W'(32'h41454144);
      1: return W'(mie[c] * 16);
      2: return W'(mq[c].size() * 256 + mie[c] * 16 + mil[c] * 8 + mov[c] * 4 + mrv[c] * 2 +
                   int'(mph[c] == 0 && mq[c].size() == 0 && core_ready[c]));
      3: return mkey[c];
      4: return mnon[c];
      5: return mdat[c];
      6: return mres[c];
      7: return W'(merr[c]);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int c, r;
    c = int'(address[7:4]);
    r = int'(address[3:0]);
    if (rst) begin
      mlive = 1;
      mread = '0;
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        mph[i] = 0; mcmd[i] = 0; mkey[i] = '0; mnon[i] = '0; mdat[i] = '0; mres[i] = '0;
        mrv[i] = 0; mov[i] = 0; mil[i] = 0; mie[i] = 0; merr[i] = 0;
      end
    end else begin
      if (cs && !we) mread = mview(c, r);
      for (int i = 0; i < N; i++) begin
        bit pop, busy, sel, e;
        logic [2:0] b;
        pop = mph[i] == 0 && mq[i].size() > 0 && core_ready[i];
        busy = mph[i] != 0 || mq[i].size() > 0;
        sel = cs && we && c == i;
        e = 0;
        b = write_data[2:0];
        if (sel && r == 1) begin
          mie[i] = write_data[4];
          if (b == 1 || b == 2 || b == 4) begin
            if (mq[i].size() < D || pop) mq[i].push_back(b);
            else begin mov[i] = 1; e = 1; end
          end else if (b != 0) begin
            mil[i] = 1; e = 1;
          end
        end
        if (sel && r >= 3 && r <= 5) begin
          if (busy) e = 1;
          else if (r == 3) mkey[i] = write_data;
          else if (r == 4) mnon[i] = write_data;
          else mdat[i] = write_data;
        end
        if (sel && r == 1 && write_data[7]) begin
          mov[i] = 0; mil[i] = 0; merr[i] = 0;
        end else if (e && merr[i] < 65535) merr[i]++;
        if (core_result_valid[i]) begin
          mres[i] = core_result[i*W +: W]; mrv[i] = 1;
        end else if (cs && !we && c == i && r == 6) mrv[i] = 0;
        if (pop) begin
          mcmd[i] = mq[i].pop_front(); mph[i] = 1;
        end else if (mph[i] == 1) mph[i] = 2;
        else if (mph[i] == 2 && core_ready[i]) mph[i] = 0;
      end
    end
  end

  always @(negedge clk) if (mlive) begin
    logic [3*N-1:0] ep;
    bit ei;
    ep = '0;
    ei = 0;
    for (int i = 0; i < N; i++) begin
      if (mph[i] == 1) begin
        ep[i] = mcmd[i][0]; ep[N+i] = mcmd[i][1]; ep[2*N+i] = mcmd[i][2];
      end
      ei = ei | (mrv[i] & mie[i]);
      checks++;
      if (core_key[i*W +: W] !== mkey[i] || core_nonce[i*W +: W] !== mnon[i] || core_data[i*W +: W] !== mdat[i]) begin
        errors++;
        $display("FAIL regs ch%0d: key lsw got %h want %h", i, core_key[i*W +: 32], mkey[i][31:0]);
      end
    end
    chk("pulses", W'({core_done, core_next, core_init}), W'(ep));
    chk("irq", W'(irq), W'(ei));
    chk("read_data", read_data, mread);
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(int c, int r, logic [W-1:0] d);
    cs = 1; we = 1; address = AW'(c * 16 + r); write_data = d;
    step(1);
    cs = 0; we = 0;
  endtask
  task automatic rd(int c, int r);
    cs = 1; we = 0; address = AW'(c * 16 + r);
    step(1);
    cs = 0;
  endtask
  task automatic count_pulses(int n, int c, output int ni, output int nn, output int nd);
    ni = 0; nn = 0; nd = 0;
    repeat (n) begin
      step(1);
      ni += int'(core_init[c]); nn += int'(core_next[c]); nd += int'(core_done[c]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ni, nn, nd;
    rst = 1; cs = 0; we = 0; address = '0; write_data = '0;
    core_ready = '1; core_result_valid = '0; core_result = '0;
    step(2);
    rst = 0;
    rd(0, 0); chk("id", W'(read_data[31:0]), W'(32'h41454144));
    rd(0, 2); chk("status0_reset", read_data, W'('h1));
    // single init on ch1, two edges after the CTRL write
    wr(1, 3, {16{32'h00112233}});
    wr(1, 1, W'(1));
    chk("init1_early", W'(core_init[1]), W'(0));
    step(1); chk("init1_pulse", W'(core_init[1]), W'(1));
    step(1); chk("init1_end", W'(core_init[1]), W'(0));
    chk("key1", core_key[W +: W], {16{32'h00112233}});
    step(2);
    // FIFO overflow on ch2 while the core is not ready
    core_ready[2] = 0;
    repeat (5) wr(2, 1, W'(2));
    rd(2, 2); chk("status2_full", read_data, W'('h404));
    rd(2, 7); chk("errcnt2", read_data, W'(1));
    core_ready[2] = 1;
    count_pulses(20, 2, ni, nn, nd);
    chk("next2_count", W'(nn), W'(4));
    // key/data write while busy is dropped
    core_ready[1] = 0;
    wr(1, 1, W'(1));
    wr(1, 5, {16{32'h12345678}});
    rd(1, 7); chk("errcnt1_busy", read_data, W'(1));
    chk("data1_dropped", core_data[W +: W], W'(0));
    core_ready[1] = 1;
    step(6);
    // illegal command then clear
    wr(0, 1, W'(3));
    count_pulses(5, 0, ni, nn, nd);
    chk("illegal_no_pulse", W'(ni + nn + nd), W'(0));
    rd(0, 2); chk("status0_illegal", read_data, W'('h9));
    rd(0, 7); chk("errcnt0_illegal", read_data, W'(1));
    wr(0, 1, W'('h80));
    rd(0, 2); chk("status0_clear", read_data, W'('h1));
    rd(0, 7); chk("errcnt0_clear", read_data, W'(0));
    wr(0, 1, W'(3));
    wr(0, 1, W'('h83));
    rd(0, 7); chk("errcnt0_clr_wins", read_data, W'(0));
    rd(0, 2); chk("status0_clr_wins", read_data, W'('h1));
    // result capture and irq on ch3
    wr(3, 1, W'('h10));
    core_result[3*W +: W] = {16{32'hdeadbeef}};
    core_result_valid[3] = 1;
    step(1);
    core_result_valid[3] = 0;
    chk("irq_set", W'(irq), W'(1));
    rd(3, 6);
    chk("result3", read_data, {16{32'hdeadbeef}});
    chk("irq_clear", W'(irq), W'(0));
    core_result[3*W +: W] = {16{32'hcafef00d}};
    core_result_valid[3] = 1;
    cs = 1; we = 0; address = AW'(3 * 16 + 6);
    step(1);
    cs = 0; core_result_valid[3] = 0;
    chk("result3_old", read_data, {16{32'hdeadbeef}});
    chk("irq_capture_wins", W'(irq), W'(1));
    rd(3, 6);
    chk("result3_new", read_data, {16{32'hcafef00d}});
    chk("irq_clear2", W'(irq), W'(0));
    rd(4, 0); chk("ch4_reads_zero", read_data, W'(0));
    // reset while ch0 waits with two commands queued
    wr(0, 1, W'(2));
    step(1);
    core_ready[0] = 0;
    wr(0, 1, W'(2));
    wr(0, 1, W'(4));
    rd(0, 2); chk("status0_wait", read_data, W'('h200));
    rst = 1;
    step(1);
    chk("rst_pulses", W'({core_done, core_next, core_init}), W'(0));
    chk("rst_read", read_data, W'(0));
    chk("rst_irq", W'(irq), W'(0));
    chk("rst_key", W'(|core_key), W'(0));
    rst = 0;
    core_ready = '1;
    count_pulses(10, 0, ni, nn, nd);
    chk("rst_no_pulses", W'(ni + nn + nd), W'(0));
    rd(0, 2); chk("status0_after_rst", read_data, W'('h1));
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
